// File: rtl/udp_pkg.sv
// udp_pkg: shared types and defaults for the UDP transmit arbiter.
// FSM state encoding, default sizing and timeout counter width.
package udp_pkg;

  localparam int DEF_NUM_SRC        = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int TMO_W              = 16;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/udp_rr_pick.sv
// udp_rr_pick: combinational round-robin picker.
// Returns the first set req bit searching ptr, ptr+1, ... mod N.
import udp_pkg::*;

module udp_rr_pick #(
  parameter  int N  = DEF_NUM_SRC,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any_req
);

  int            s;
  logic [IW-1:0] idx;

  // scan requesters starting at the pointer, wrapping once
  always_comb begin
    gnt_idx = '0;
    any_req = 1'b0;
    s       = 0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      s = int'(ptr) + k;
      if (s >= N) s = s - N;
      idx = IW'(s);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin byte-stream arbiter feeding one transmitter.
// Optional completion timeout enabled by macro UDP_TX_ARB_TIMEOUT_EN.
import udp_pkg::*;

module udp_tx_arbiter #(
  parameter  int NUM_SRC        = DEF_NUM_SRC,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [NUM_SRC-1:0]   src_first,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic [7:0]           tx_in,
  output logic                 tx_in_valid,
  output logic                 tx_in_first,
  output logic                 tx_in_last,
  input  logic                 wr_valid,
  input  logic                 wr_last,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic                 pkt_done,
  output logic                 timeout_err
);

  arb_state_t         state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      next_ptr;
  logic               any_req;
  logic [NUM_SRC-1:0] req;
  logic [7:0]         sel_data;
  logic               sel_valid;
  logic               sel_first;
  logic               sel_last;
  logic               acc;
  logic               done;

`ifdef UDP_TX_ARB_TIMEOUT_EN
  logic [TMO_W-1:0]   tmo_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  assign req  = src_valid & src_first;
  assign busy = (state != IDLE);
  assign done = wr_valid & wr_last;
  assign acc  = (state == FWD) && sel_valid;

  assign next_ptr = (grant_id == IW'(NUM_SRC - 1)) ?
                    '0 : grant_id + 1'b1;

  udp_rr_pick #(
    .N(NUM_SRC)
  ) u_pick (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .any_req (any_req)
  );

  // mux the granted requester and open its ready only while forwarding
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_first = 1'b0;
    sel_last  = 1'b0;
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == IW'(i)) begin
        sel_data  = src_data[8*i +: 8];
        sel_valid = src_valid[i];
        sel_first = src_first[i];
        sel_last  = src_last[i];
        src_ready[i] = (state == FWD);
      end
    end
  end

  // one-cycle registered byte path; idle cycles become invalid beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_in       <= '0;
      tx_in_valid <= 1'b0;
      tx_in_first <= 1'b0;
      tx_in_last  <= 1'b0;
    end else begin
      tx_in_valid <= acc;
      tx_in_first <= acc && sel_first;
      tx_in_last  <= acc && sel_last;
      if (acc) tx_in <= sel_data;
    end
  end

  // arbitration / completion state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      pkt_done <= 1'b0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      pkt_done <= 1'b0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= pick_idx;
            state    <= FWD;
          end
        end
        FWD: begin
          if (acc && sel_last) begin
            rr_ptr <= next_ptr;
            state  <= WAIT_DONE;
`ifdef UDP_TX_ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        WAIT_DONE: begin
          if (done) begin
            pkt_done <= 1'b1;
            state    <= IDLE;
          end
`ifdef UDP_TX_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: self-checking bench for udp_tx_arbiter.
// Packet-level round-robin model, table vectors and directed corners.
module tb_udp_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [8*N-1:0] src_data;
  logic [N-1:0]   src_valid, src_first, src_last;
  logic [N-1:0]   src_ready;
  logic [7:0]     tx_in;
  logic           tx_in_valid, tx_in_first, tx_in_last;
  logic           wr_valid, wr_last;
  logic [1:0]     grant_id;
  logic           busy, pkt_done, timeout_err;

  udp_tx_arbiter #(
    .NUM_SRC        (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .src_first   (src_first),
    .src_last    (src_last),
    .src_ready   (src_ready),
    .tx_in       (tx_in),
    .tx_in_valid (tx_in_valid),
    .tx_in_first (tx_in_first),
    .tx_in_last  (tx_in_last),
    .wr_valid    (wr_valid),
    .wr_last     (wr_last),
    .grant_id    (grant_id),
    .busy        (busy),
    .pkt_done    (pkt_done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         f;
    bit         l;
    int         gap;
  } beat_t;

  typedef struct {
    logic [7:0] d;
    bit         f;
    bit         l;
    int         src;
  } exp_t;

  typedef struct {
    int         prior;
    logic [3:0] req;
    int         gnt;
  } vec_t;

  beat_t srcq[N][$];
  exp_t  expq[$];
  vec_t  vt[8];
  int    n_chk = 0;
  int    n_fail = 0;
  int    mptr = 0;
  int    mid_idle;
  int    beats_seen;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_src();
    src_valid = '0;
    src_first = '0;
    src_last  = '0;
    src_data  = '0;
  endtask

  task automatic do_reset();
    clear_src();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mptr  = 0;
  endtask

  // reference: order packets by round robin over sources that hold any
  function automatic int build_expect();
    int   cnt[N];
    int   pos[N];
    int   tot;
    int   o;
    exp_t e;
    tot = 0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      pos[i] = 0;
      foreach (srcq[i][j]) if (srcq[i][j].l) cnt[i]++;
      tot += cnt[i];
    end
    for (int p = 0; p < tot; p++) begin
      o = -1;
      for (int k = 0; k < N; k++)
        if (o < 0 && cnt[(mptr + k) % N] > 0) o = (mptr + k) % N;
      cnt[o]--;
      do begin
        e.d   = srcq[o][pos[o]].d;
        e.f   = srcq[o][pos[o]].f;
        e.l   = srcq[o][pos[o]].l;
        e.src = o;
        expq.push_back(e);
        pos[o]++;
      end while (!srcq[o][pos[o]-1].l);
      mptr = (o + 1) % N;
    end
    return tot;
  endfunction

  // drive all queued sources, complete each packet, compare the stream
  task automatic run_engine(input int wr_max);
    bit   acc[N];
    bit   fresh[N];
    int   gap_left[N];
    int   wr_pend, cyc, npk, ndone;
    bit   fin, in_out, acc_any, qe;
    exp_t e;
    npk = build_expect();
    ndone = 0; wr_pend = -1; cyc = 0; fin = 0; in_out = 0;
    mid_idle = 0; beats_seen = 0; acc_any = 0;
    for (int i = 0; i < N; i++) begin
      acc[i] = 0; fresh[i] = 1; gap_left[i] = 0;
    end
    while (!fin && cyc < 3000) begin
      tick();
      for (int i = 0; i < N; i++)
        if (acc[i]) begin
          void'(srcq[i].pop_front());
          fresh[i] = 1;
        end
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      if (wr_pend == 0) begin
        wr_valid = 1'b1; wr_last = 1'b1; wr_pend = -1;
      end else if (wr_pend > 0) wr_pend--;
      for (int i = 0; i < N; i++) begin
        src_valid[i] = 0; src_first[i] = 0; src_last[i] = 0;
        src_data[8*i +: 8] = 8'h00;
        if (srcq[i].size() > 0) begin
          if (fresh[i]) begin
            gap_left[i] = srcq[i][0].gap;
            fresh[i] = 0;
          end
          if (gap_left[i] > 0) gap_left[i]--;
          else begin
            src_valid[i] = 1'b1;
            src_first[i] = srcq[i][0].f;
            src_last[i]  = srcq[i][0].l;
            src_data[8*i +: 8] = srcq[i][0].d;
          end
        end
      end
      @(negedge clk);
      cyc++;
      if (pkt_done) ndone++;
      chk("tx_valid_latency", tx_in_valid, acc_any);
      if (tx_in_valid) begin
        if (expq.size() == 0) chk("extra_beat", tx_in_valid, 0);
        else begin
          e = expq.pop_front();
          beats_seen++;
          chk("tx_data", tx_in, e.d);
          chk("tx_first", tx_in_first, e.f);
          chk("tx_last", tx_in_last, e.l);
          chk("tx_owner", grant_id, e.src);
          in_out = !e.l;
          if (e.l) begin
            chk("wait_done_busy", busy, 1);
            chk("wait_done_ready", src_ready, 0);
            wr_pend = $urandom_range(wr_max, 0);
          end
        end
      end else if (in_out) mid_idle++;
      chk("ready_onehot", $countones(src_ready) <= 1, 1);
      acc_any = 0;
      for (int i = 0; i < N; i++) begin
        acc[i] = src_ready[i] && src_valid[i];
        acc_any |= acc[i];
      end
      qe = 1;
      for (int i = 0; i < N; i++) if (srcq[i].size() > 0) qe = 0;
      if (qe && expq.size() == 0 && wr_pend < 0 && !busy && !wr_valid)
        fin = 1;
    end
    chk("run_complete", fin, 1);
    chk("pkt_done_count", ndone, npk);
    for (int i = 0; i < N; i++) srcq[i].delete();
    expq.delete();
    clear_src();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic push(input int s, input logic [7:0] d,
                      input bit f, input bit l, input int gap);
    beat_t b;
    b.d = d; b.f = f; b.l = l; b.gap = gap;
    srcq[s].push_back(b);
  endtask

  task automatic send_single(input int s, input logic [7:0] d);
    int n;
    clear_src();
    src_valid[s] = 1'b1;
    src_first[s] = 1'b1;
    src_last[s]  = 1'b1;
    src_data[8*s +: 8] = d;
    n = 0;
    @(negedge clk);
    while (!src_ready[s] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant_wait", src_ready[s], 1);
    tick();
    clear_src();
    wr_valid = 1'b1;
    wr_last  = 1'b1;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic to_wait_done(input logic [7:0] d);
    clear_src();
    src_valid[0] = 1'b1;
    src_first[0] = 1'b1;
    src_last[0]  = 1'b1;
    src_data[7:0] = d;
    tick();
    tick();
    clear_src();
  endtask

  initial begin
    logic [7:0] pkt29[29];
    logic [3:0] m;
    int         len, np;

    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    clear_src();

    vt[0] = '{prior: 3, req: 4'b1010, gnt: 1};
    vt[1] = '{prior: 0, req: 4'b0001, gnt: 0};
    vt[2] = '{prior: 1, req: 4'b0011, gnt: 0};
    vt[3] = '{prior: 2, req: 4'b1001, gnt: 3};
    vt[4] = '{prior: 2, req: 4'b0110, gnt: 1};
    vt[5] = '{prior: 0, req: 4'b1101, gnt: 2};
    vt[6] = '{prior: 3, req: 4'b1000, gnt: 3};
    vt[7] = '{prior: 1, req: 4'b1111, gnt: 2};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_tx_valid", tx_in_valid, 0);
    chk("rst_tx_in", tx_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", src_ready, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_tmo", timeout_err, 0);
    rst_n = 1'b1;

    // contention: src1 and src3 together, then src0 and src2
    push(1, 8'h11, 1, 0, 0); push(1, 8'h12, 0, 1, 0);
    push(3, 8'h31, 1, 0, 0); push(3, 8'h32, 0, 1, 0);
    run_engine(2);
    push(0, 8'h01, 1, 1, 0);
    push(2, 8'h21, 1, 1, 0);
    run_engine(1);

    // 29-byte packet from src0
    pkt29[0] = 8'd24; pkt29[1] = 8'd49; pkt29[2] = 8'd112;
    for (int i = 3; i < 28; i++) pkt29[i] = 8'(i * 7 + 3);
    pkt29[28] = 8'd98;
    for (int i = 0; i < 29; i++)
      push(0, pkt29[i], i == 0, i == 28, 0);
    run_engine(0);
    chk("p29_beats", beats_seen, 29);

    // 3-cycle gap in the middle of a packet
    for (int i = 0; i < 10; i++)
      push(1, 8'(8'h40 + i), i == 0, i == 9, (i == 5) ? 3 : 0);
    run_engine(0);
    chk("gap_idle_cycles", mid_idle, 3);
    chk("gap_beats", beats_seen, 10);

    // single-byte packet; completion pulse in FWD is ignored
    clear_src();
    src_valid[0] = 1'b1; src_first[0] = 1'b1; src_last[0] = 1'b1;
    src_data[7:0] = 8'hAB;
    tick();
    @(negedge clk);
    chk("sb_ready", src_ready, 4'b0001);
    chk("sb_busy_fwd", busy, 1);
    wr_valid = 1'b1; wr_last = 1'b1;
    tick();
    clear_src();
    wr_valid = 1'b0; wr_last = 1'b0;
    @(negedge clk);
    chk("sb_tx", {tx_in_valid, tx_in_first, tx_in_last, tx_in},
        {3'b111, 8'hAB});
    chk("sb_busy_wait", busy, 1);
    tick();
    @(negedge clk);
    chk("sb_still_wait", busy, 1);
    chk("sb_no_done", pkt_done, 0);
    wr_valid = 1'b1; wr_last = 1'b1;
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
    @(negedge clk);
    chk("sb_done", pkt_done, 1);
    chk("sb_idle", busy, 0);
    tick();
    @(negedge clk);
    chk("sb_done_pulse", pkt_done, 0);

    // table: prior owner sets the pointer, then a request mask
    do_reset();
    for (int v = 0; v < 8; v++) begin
      send_single(vt[v].prior, 8'h77);
      clear_src();
      for (int i = 0; i < N; i++)
        if (vt[v].req[i]) begin
          src_valid[i] = 1'b1; src_first[i] = 1'b1; src_last[i] = 1'b1;
          src_data[8*i +: 8] = 8'(16 + i);
        end
      tick();
      @(negedge clk);
      m = 4'b0001 << vt[v].gnt;
      chk("vec_grant", grant_id, vt[v].gnt);
      chk("vec_ready", src_ready, m);
      tick();
      clear_src();
      @(negedge clk);
      chk("vec_tx", {tx_in_first, tx_in_last, tx_in},
          {2'b11, 8'(16 + vt[v].gnt)});
      wr_valid = 1'b1; wr_last = 1'b1;
      tick();
      wr_valid = 1'b0; wr_last = 1'b0;
    end

    // completion timeout
    to_wait_done(8'h5A);
`ifdef UDP_TX_ARB_TIMEOUT_EN
    for (int k = 1; k <= 9; k++) begin
      tick();
      @(negedge clk);
      chk("tmo_err", timeout_err, k == 8);
      chk("tmo_busy", busy, k < 8);
    end
    to_wait_done(8'h5B);
    for (int k = 1; k <= 7; k++) begin
      tick();
      @(negedge clk);
    end
    wr_valid = 1'b1; wr_last = 1'b1;
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
    @(negedge clk);
    chk("tmo_tie_done", pkt_done, 1);
    chk("tmo_tie_err", timeout_err, 0);
    chk("tmo_tie_idle", busy, 0);
`else
    for (int k = 1; k <= 20; k++) begin
      tick();
      @(negedge clk);
      chk("notmo_busy", busy, 1);
      chk("notmo_err", timeout_err, 0);
    end
    wr_valid = 1'b1; wr_last = 1'b1;
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
    @(negedge clk);
    chk("notmo_done", pkt_done, 1);
`endif

    // reset on the 5th byte of a packet, pointer left at 3 beforehand
    send_single(2, 8'h22);
    clear_src();
    src_valid[0] = 1'b1; src_first[0] = 1'b1;
    src_data[7:0] = 8'h50;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      src_first[0] = 1'b0;
      src_data[7:0] = 8'(8'h50 + k);
    end
    @(negedge clk);
    chk("pre_rst_valid", tx_in_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_tx", {tx_in_valid, tx_in_first, tx_in_last, tx_in}, 0);
    chk("arst_ready", src_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_grant", grant_id, 0);
    chk("arst_flags", {pkt_done, timeout_err}, 0);
    clear_src();
    @(negedge clk);
    rst_n = 1'b1;
    mptr  = 0;
    push(3, 8'h33, 1, 1, 0);
    push(2, 8'h61, 1, 0, 0); push(2, 8'h62, 0, 1, 0);
    run_engine(1);

    // random traffic against the packet-level model
    do_reset();
    for (int r = 0; r < 25; r++) begin
      for (int s = 0; s < N; s++) begin
        np = $urandom_range(2, 0);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(6, 1);
          for (int j = 0; j < len; j++)
            push(s, 8'($urandom),
                 (j == 0) ? 1'b1 : ($urandom_range(9, 0) == 0),
                 j == len - 1,
                 (j == 0) ? 0 :
                 (($urandom_range(3, 0) == 0) ? $urandom_range(2, 1) : 0));
        end
      end
      run_engine(3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
